// File: rtl/regfile_pkg.sv
// rtl/regfile_pkg.sv - shared widths for the register file and operand fetch stage
// Contents: DW (data width), AW (register address width), OPW (opcode width),
//           NREGS (number of architectural registers, 2**AW).
package regfile_pkg;
  localparam int DW    = 8;
  localparam int AW    = 3;
  localparam int OPW   = 4;
  localparam int NREGS = 1 << AW;
endpackage

// File: rtl/operand_fetch_if.sv
// rtl/operand_fetch_if.sv - instruction, regfile-read, writeback and execute-side bus of operand_fetch
// Signals:
//   in_*      upstream instruction handshake (valid/ready, op, rs1, rs2, rd, rd_we)
//   raddr*    regfile read addresses, rdata* asynchronous read data
//   wb_*      writeback stream (same strobe as the regfile write port)
//   out_*     registered operands to execute (valid/ready, op, a, b, rd, rd_we)
// Modports: slave = operand_fetch view, master = driver of instructions/regfile/execute.
interface operand_fetch_if #(
  parameter int DW  = regfile_pkg::DW,
  parameter int AW  = regfile_pkg::AW,
  parameter int OPW = regfile_pkg::OPW
);
  logic           in_valid;
  logic           in_ready;
  logic [OPW-1:0] in_op;
  logic [AW-1:0]  in_rs1;
  logic [AW-1:0]  in_rs2;
  logic [AW-1:0]  in_rd;
  logic           in_rd_we;
  logic [AW-1:0]  raddr1;
  logic [AW-1:0]  raddr2;
  logic [DW-1:0]  rdata1;
  logic [DW-1:0]  rdata2;
  logic           wb_we;
  logic [AW-1:0]  wb_addr;
  logic [DW-1:0]  wb_data;
  logic           out_valid;
  logic           out_ready;
  logic [OPW-1:0] out_op;
  logic [DW-1:0]  out_a;
  logic [DW-1:0]  out_b;
  logic [AW-1:0]  out_rd;
  logic           out_rd_we;

  modport slave (
    input  in_valid, in_op, in_rs1, in_rs2, in_rd, in_rd_we,
    output in_ready,
    output raddr1, raddr2,
    input  rdata1, rdata2,
    input  wb_we, wb_addr, wb_data,
    output out_valid, out_op, out_a, out_b, out_rd, out_rd_we,
    input  out_ready
  );

  modport master (
    output in_valid, in_op, in_rs1, in_rs2, in_rd, in_rd_we,
    input  in_ready,
    input  raddr1, raddr2,
    output rdata1, rdata2,
    output wb_we, wb_addr, wb_data,
    input  out_valid, out_op, out_a, out_b, out_rd, out_rd_we,
    output out_ready
  );
endinterface

// File: rtl/opf_scoreboard.sv
// rtl/opf_scoreboard.sv - pending-destination-write bit vector for operand_fetch
// Ports:
//   clk, rst_n            clock, synchronous active-low reset (clears all pending bits)
//   set_en, set_addr      mark a register as having a write in flight
//   clr_en, clr_addr      writeback retires the pending write
//   rs1, rs2, rd          lookup addresses
//   hit1, hit2, hitd      pending bit of rs1 / rs2 / rd
module opf_scoreboard #(
  parameter int AW = regfile_pkg::AW
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          set_en,
  input  logic [AW-1:0] set_addr,
  input  logic          clr_en,
  input  logic [AW-1:0] clr_addr,
  input  logic [AW-1:0] rs1,
  input  logic [AW-1:0] rs2,
  input  logic [AW-1:0] rd,
  output logic          hit1,
  output logic          hit2,
  output logic          hitd
);
  localparam int NREGS = 1 << AW;

  logic [NREGS-1:0] sb;
  logic [NREGS-1:0] sb_next;

  // Clear is applied before set so a new issue to the register being
  // written back in the same cycle stays pending. Clearing an idle bit is harmless.
  always_comb begin
    sb_next = sb;
    if (clr_en) sb_next[clr_addr] = 1'b0;
    if (set_en) sb_next[set_addr] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) sb <= '0;
    else        sb <= sb_next;
  end

  assign hit1 = sb[rs1];
  assign hit2 = sb[rs2];
  assign hitd = sb[rd];
endmodule

// File: rtl/operand_fetch.sv
// rtl/operand_fetch.sv - decode-to-execute operand fetch stage with RAW/WAW scoreboard stall
// Ports:
//   clk    rising-edge clock
//   rst_n  synchronous active-low reset; drops the in-flight instruction and pending writes
//   bus    operand_fetch_if.slave: instruction in, regfile read, writeback, operands out
// Option: OPF_FWD_EN bypasses same-cycle writeback data into out_a/out_b so a RAW
//         hit coinciding with wb_we does not stall. Undefined: stall one extra cycle.
module operand_fetch #(
  parameter int DW  = regfile_pkg::DW,
  parameter int AW  = regfile_pkg::AW,
  parameter int OPW = regfile_pkg::OPW
) (
  input logic               clk,
  input logic               rst_n,
  operand_fetch_if.slave    bus
);
  logic           fwd1;
  logic           fwd2;
  logic           hit1;
  logic           hit2;
  logic           hitd;
  logic           hazard;
  logic           accept;
  logic [DW-1:0]  a_sel;
  logic [DW-1:0]  b_sel;

  logic           vld_q;
  logic [OPW-1:0] op_q;
  logic [DW-1:0]  a_q;
  logic [DW-1:0]  b_q;
  logic [AW-1:0]  rd_q;
  logic           rd_we_q;

  assign bus.raddr1 = bus.in_rs1;
  assign bus.raddr2 = bus.in_rs2;

`ifdef OPF_FWD_EN
  assign fwd1 = bus.wb_we & (bus.wb_addr == bus.in_rs1);
  assign fwd2 = bus.wb_we & (bus.wb_addr == bus.in_rs2);
`else
  assign fwd1 = 1'b0;
  assign fwd2 = 1'b0;
  // Without bypass the data only reaches execute through the regfile.
  logic [DW-1:0] unused_wb_data;
  assign unused_wb_data = bus.wb_data;
`endif

  opf_scoreboard #(.AW(AW)) u_sb (
    .clk      (clk),
    .rst_n    (rst_n),
    .set_en   (accept & bus.in_rd_we),
    .set_addr (bus.in_rd),
    .clr_en   (bus.wb_we),
    .clr_addr (bus.wb_addr),
    .rs1      (bus.in_rs1),
    .rs2      (bus.in_rs2),
    .rd       (bus.in_rd),
    .hit1     (hit1),
    .hit2     (hit2),
    .hitd     (hitd)
  );

  // WAW is never forwarded: the older write must retire so only one write per register is in flight.
  assign hazard       = (hit1 & ~fwd1) | (hit2 & ~fwd2) | (bus.in_rd_we & hitd);
  assign bus.in_ready = ~hazard & (~vld_q | bus.out_ready);
  assign accept       = bus.in_valid & bus.in_ready;

  assign a_sel = fwd1 ? bus.wb_data : bus.rdata1;
  assign b_sel = fwd2 ? bus.wb_data : bus.rdata2;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      vld_q   <= 1'b0;
      op_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      rd_q    <= '0;
      rd_we_q <= 1'b0;
    end else if (accept) begin
      vld_q   <= 1'b1;
      op_q    <= bus.in_op;
      a_q     <= a_sel;
      b_q     <= b_sel;
      rd_q    <= bus.in_rd;
      rd_we_q <= bus.in_rd_we;
    end else if (bus.out_ready) begin
      vld_q   <= 1'b0;
    end
  end

  assign bus.out_valid = vld_q;
  assign bus.out_op    = op_q;
  assign bus.out_a     = a_q;
  assign bus.out_b     = b_q;
  assign bus.out_rd    = rd_q;
  assign bus.out_rd_we = rd_we_q;
endmodule

// File: tb/tb_operand_fetch.sv
// tb/tb_operand_fetch.sv - self-checking bench for operand_fetch with a regfile model and output scoreboard
module tb_operand_fetch;
  import regfile_pkg::*;

`ifdef OPF_FWD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  typedef struct {
    logic       v;
    logic [3:0] op;
    logic [2:0] rs1;
    logic [2:0] rs2;
    logic [2:0] rd;
    logic       rd_we;
    logic       wbwe;
    logic [2:0] wba;
    logic [7:0] wbd;
    logic       ordy;
    logic       rdy_f;
    logic       rdy_n;
  } vec_t;

  typedef struct {
    logic [3:0] op;
    logic [7:0] a;
    logic [7:0] b;
    logic [2:0] rd;
    logic       rd_we;
  } exp_t;

  logic clk;
  logic rst_n;
  logic [7:0] rf [8];
  exp_t q[$];
  logic mov;
  int errors;
  int checks;
  vec_t tbl [24];

  operand_fetch_if ifc ();

  operand_fetch dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (ifc.slave)
  );

  assign ifc.rdata1 = rf[ifc.raddr1];
  assign ifc.rdata2 = rf[ifc.raddr2];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic vec_t mk(logic v, logic [3:0] op, logic [2:0] rs1, logic [2:0] rs2,
                              logic [2:0] rd, logic rd_we, logic wbwe, logic [2:0] wba,
                              logic [7:0] wbd, logic ordy, logic rdy_f, logic rdy_n);
    vec_t r;
    r.v = v; r.op = op; r.rs1 = rs1; r.rs2 = rs2; r.rd = rd; r.rd_we = rd_we;
    r.wbwe = wbwe; r.wba = wba; r.wbd = wbd; r.ordy = ordy; r.rdy_f = rdy_f; r.rdy_n = rdy_n;
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic apply_row(input vec_t r, input int idx);
    exp_t e;
    logic rdy;
    logic acc;
    ifc.in_valid  = r.v;
    ifc.in_op     = r.op;
    ifc.in_rs1    = r.rs1;
    ifc.in_rs2    = r.rs2;
    ifc.in_rd     = r.rd;
    ifc.in_rd_we  = r.rd_we;
    ifc.wb_we     = r.wbwe;
    ifc.wb_addr   = r.wba;
    ifc.wb_data   = r.wbd;
    ifc.out_ready = r.ordy;
    @(negedge clk);
    rdy = FWD ? r.rdy_f : r.rdy_n;
    chk($sformatf("in_ready[%0d]", idx), ifc.in_ready, rdy);
    chk($sformatf("out_valid[%0d]", idx), ifc.out_valid, mov);
    if (mov && q.size() > 0) begin
      chk($sformatf("out_op[%0d]", idx), ifc.out_op, q[0].op);
      chk($sformatf("out_a[%0d]", idx), ifc.out_a, q[0].a);
      chk($sformatf("out_b[%0d]", idx), ifc.out_b, q[0].b);
      chk($sformatf("out_rd[%0d]", idx), ifc.out_rd, q[0].rd);
      chk($sformatf("out_rd_we[%0d]", idx), ifc.out_rd_we, q[0].rd_we);
      if (r.ordy) void'(q.pop_front());
    end
    acc = r.v & rdy;
    if (acc) begin
      e.op    = r.op;
      e.a     = (FWD && r.wbwe && r.wba == r.rs1) ? r.wbd : rf[r.rs1];
      e.b     = (FWD && r.wbwe && r.wba == r.rs2) ? r.wbd : rf[r.rs2];
      e.rd    = r.rd;
      e.rd_we = r.rd_we;
      q.push_back(e);
    end
    mov = acc ? 1'b1 : (r.ordy ? 1'b0 : mov);
    @(posedge clk);
    if (r.wbwe) rf[r.wba] = r.wbd;
    #1;
  endtask

  initial begin
    errors = 0;
    checks = 0;
    mov = 1'b0;
    for (int i = 0; i < 8; i++) rf[i] = 8'h10 + 8'(i);
    rf[1] = 8'hAA;
    rf[2] = 8'h55;

    // independent op, RAW on r4, WAW on r5, RAW after re-set of r5
    tbl[0]  = mk(1, 4'h1, 1, 2, 3, 0, 0, 0, 8'h00, 1, 1, 1);
    tbl[1]  = mk(1, 4'h2, 0, 0, 4, 1, 0, 0, 8'h00, 1, 1, 1);
    tbl[2]  = mk(1, 4'h3, 4, 1, 7, 0, 0, 0, 8'h00, 1, 0, 0);
    tbl[3]  = mk(1, 4'h3, 4, 1, 7, 0, 1, 4, 8'h3C, 1, 1, 0);
    tbl[4]  = mk(1, 4'h3, 4, 1, 7, 0, 0, 0, 8'h00, 1, 1, 1);
    tbl[5]  = mk(1, 4'h4, 0, 0, 5, 1, 0, 0, 8'h00, 1, 1, 1);
    tbl[6]  = mk(1, 4'h5, 1, 2, 5, 1, 0, 0, 8'h00, 1, 0, 0);
    tbl[7]  = mk(1, 4'h5, 1, 2, 5, 1, 1, 5, 8'h77, 1, 0, 0);
    tbl[8]  = mk(1, 4'h5, 1, 2, 5, 1, 0, 0, 8'h00, 1, 1, 1);
    tbl[9]  = mk(1, 4'h6, 5, 0, 0, 0, 0, 0, 8'h00, 1, 0, 0);
    tbl[10] = mk(1, 4'h6, 5, 0, 0, 0, 1, 5, 8'h99, 1, 1, 0);
    tbl[11] = mk(1, 4'h6, 5, 0, 0, 0, 0, 0, 8'h00, 1, 1, 1);
    // set/clear collision on r6, then reads of r6
    tbl[12] = mk(1, 4'h7, 1, 2, 6, 1, 1, 6, 8'h12, 1, 1, 1);
    tbl[13] = mk(1, 4'h8, 6, 6, 1, 0, 0, 0, 8'h00, 1, 0, 0);
    tbl[14] = mk(0, 4'h8, 6, 6, 1, 0, 1, 6, 8'h34, 1, 1, 0);
    tbl[15] = mk(1, 4'h8, 6, 6, 1, 0, 0, 0, 8'h00, 1, 1, 1);
    // writeback to an idle register is ignored by the scoreboard
    tbl[16] = mk(0, 4'h0, 2, 2, 0, 0, 1, 2, 8'h56, 1, 1, 1);
    tbl[17] = mk(1, 4'h9, 2, 3, 2, 0, 0, 0, 8'h00, 1, 1, 1);
    // backpressure: three cycles of out_ready=0 then same-cycle accept
    tbl[18] = mk(1, 4'hA, 0, 1, 2, 1, 0, 0, 8'h00, 1, 1, 1);
    tbl[19] = mk(1, 4'hB, 1, 1, 3, 0, 0, 0, 8'h00, 0, 0, 0);
    tbl[20] = mk(1, 4'hB, 1, 1, 3, 0, 0, 0, 8'h00, 0, 0, 0);
    tbl[21] = mk(1, 4'hB, 1, 1, 3, 0, 0, 0, 8'h00, 0, 0, 0);
    tbl[22] = mk(1, 4'hB, 1, 1, 3, 0, 0, 0, 8'h00, 1, 1, 1);
    tbl[23] = mk(0, 4'h0, 0, 0, 0, 0, 0, 0, 8'h00, 0, 0, 0);

    ifc.in_valid = 0; ifc.in_op = 0; ifc.in_rs1 = 0; ifc.in_rs2 = 0; ifc.in_rd = 0;
    ifc.in_rd_we = 0; ifc.wb_we = 0; ifc.wb_addr = 0; ifc.wb_data = 0; ifc.out_ready = 1;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk("reset out_valid", ifc.out_valid, 0);
    chk("reset out_op", ifc.out_op, 0);
    chk("reset out_a", ifc.out_a, 0);
    chk("reset out_b", ifc.out_b, 0);
    chk("reset out_rd", ifc.out_rd, 0);
    chk("reset out_rd_we", ifc.out_rd_we, 0);
    chk("reset in_ready", ifc.in_ready, 1);
    @(posedge clk);
    #1;

    for (int i = 0; i < 24; i++) apply_row(tbl[i], i);

    // reset with out_valid=1 and r2 pending (issued by row 18)
    rst_n = 1'b0;
    ifc.in_valid = 1'b0;
    ifc.out_ready = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b1;
    q.delete();
    mov = 1'b0;
    @(negedge clk);
    chk("midreset out_valid", ifc.out_valid, 0);
    chk("midreset out_a", ifc.out_a, 0);
    chk("midreset out_rd_we", ifc.out_rd_we, 0);
    @(posedge clk);
    #1;
    apply_row(mk(1, 4'hC, 2, 2, 0, 0, 0, 0, 8'h00, 1, 1, 1), 100);
    apply_row(mk(0, 4'h0, 0, 0, 0, 0, 0, 0, 8'h00, 1, 1, 1), 101);
    chk("queue drained", q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end
endmodule
